// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle MIPS main control FSM.
// Each instruction goes through fetch, decode, execute, memory and writeback
// states. The FSM drives the datapath enables for the current state, stalls on
// mem_ready and can time out. Illegal or disabled opcodes, and memory timeouts,
// trap into a sticky ERROR state.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   OPcode            IR[31:26]; sampled only in DECODE
//   mem_ready         memory completes the current access this cycle
//   PCWrite, PCWriteCond, PCWriteCondNe
//                     PC load: unconditional / if zero (beq) / if not zero (bne)
//   IorD, MemRead, MemWrite, IRWrite
//                     memory address select, memory requests, IR load
//   MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
//                     datapath multiplexer selects and register file write
//   estado            current state code
//   instr_fin         high during the last cycle of each instruction
//   error_code        00 ok, 01 illegal opcode, 10 memory timeout (sticky)
module unidad_control_multiciclo #(
   parameter int unsigned EN_BNE   = 1,
   parameter int unsigned EN_ADDI  = 1,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OPcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCWriteCondNe,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] MemtoReg,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [3:0] estado,
   output logic       instr_fin,
   output logic [1:0] error_code
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StREx     = 4'd6,
      StRWb     = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StJal     = 4'd10,
      StIEx     = 4'd11,
      StIWb     = 4'd12,
      StError   = 4'd15
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [WAIT_W-1:0] WaitMax   = WAIT_W'(WAIT_MAX);
   localparam bit                TimeoutEn = (WAIT_MAX != 0);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [1:0]        err_q, err_d;
   // Instruction flavour latched in DECODE, so later states need not re-read OPcode.
   logic              is_sw_q, is_sw_d;
   logic              is_bne_q, is_bne_d;

   logic in_wait;
   logic timeout;
   logic ready_ok;

   assign in_wait  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   assign timeout  = TimeoutEn && in_wait && !mem_ready && (wait_q == WaitMax);
   // Mealy enables are suppressed while reset is held.
   assign ready_ok = mem_ready & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StFetch;
         wait_q   <= '0;
         err_q    <= 2'b00;
         is_sw_q  <= 1'b0;
         is_bne_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         is_sw_q  <= is_sw_d;
         is_bne_q <= is_bne_d;
      end
   end

   // Wait counter: counts not-ready cycles, saturates, clears on leaving the wait state.
   always_comb begin
      wait_d = '0;
      if (in_wait && !mem_ready && !timeout) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      is_sw_d  = is_sw_q;
      is_bne_d = is_bne_q;
      case (state_q)
         StFetch: begin
            if (mem_ready) begin
               state_d = StDecode;
            end else if (timeout) begin
               state_d = StError;
               err_d   = 2'b10;
            end
         end
         StDecode: begin
            is_sw_d  = (OPcode == OpSw);
            is_bne_d = (OPcode == OpBne);
            case (OPcode)
               OpRtype:    state_d = StREx;
               OpLw, OpSw: state_d = StMemAddr;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpJal:      state_d = StJal;
               OpBne: begin
                  if (EN_BNE != 0) begin
                     state_d = StBranch;
                  end else begin
                     state_d = StError;
                     err_d   = 2'b01;
                  end
               end
               OpAddi: begin
                  if (EN_ADDI != 0) begin
                     state_d = StIEx;
                  end else begin
                     state_d = StError;
                     err_d   = 2'b01;
                  end
               end
               default: begin
                  state_d = StError;
                  err_d   = 2'b01;
               end
            endcase
         end
         StMemAddr: state_d = is_sw_q ? StMemWr : StMemRd;
         StMemRd, StMemWr: begin
            if (mem_ready) begin
               state_d = (state_q == StMemRd) ? StMemWb : StFetch;
            end else if (timeout) begin
               state_d = StError;
               err_d   = 2'b10;
            end
         end
         StMemWb, StRWb, StBranch, StJump, StJal, StIWb: state_d = StFetch;
         StREx:   state_d = StRWb;
         StIEx:   state_d = StIWb;
         StError: state_d = StError;
         default: state_d = StError;
      endcase
   end

   // Output decode: Moore from state_q, except the ready-qualified enables.
   always_comb begin
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      PCWriteCondNe = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 2'b00;
      PCSource      = 2'b00;
      ALUOp         = 2'b00;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      RegWrite      = 1'b0;
      RegDst        = 2'b00;
      instr_fin     = 1'b0;
      case (state_q)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = ready_ok;
            PCWrite = ready_ok;
         end
         StDecode: ALUSrcB = 2'b11;
         StMemAddr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StMemWb: begin
            RegWrite  = 1'b1;
            MemtoReg  = 2'b01;
            instr_fin = 1'b1;
         end
         StMemWr: begin
            MemWrite  = 1'b1;
            IorD      = 1'b1;
            instr_fin = ready_ok;
         end
         StREx: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         StRWb: begin
            RegWrite  = 1'b1;
            RegDst    = 2'b01;
            instr_fin = 1'b1;
         end
         StBranch: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 2'b01;
            PCSource      = 2'b01;
            PCWriteCond   = ~is_bne_q;
            PCWriteCondNe = is_bne_q;
            instr_fin     = 1'b1;
         end
         StJump: begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            instr_fin = 1'b1;
         end
         StJal: begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            RegWrite  = 1'b1;
            RegDst    = 2'b10;
            MemtoReg  = 2'b10;
            instr_fin = 1'b1;
         end
         StIEx: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StIWb: begin
            RegWrite  = 1'b1;
            instr_fin = 1'b1;
         end
         default: ;
      endcase
   end

   assign estado     = state_q;
   assign error_code = err_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: three instances (default, bne disabled,
// WAIT_MAX = 3) share stimulus; each scenario checks one of them.
module tb_unidad_control_multiciclo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] OPcode = 6'b0;
   logic       mem_ready = 1'b0;

   logic [2:0]      pcwrite, pcwritecond, pcwritecondne, iord, memread, memwrite, irwrite;
   logic [2:0]      alusrca, regwrite, instr_fin;
   logic [2:0][1:0] memtoreg, pcsource, aluop, alusrcb, regdst, error_code;
   logic [2:0][3:0] estado;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] st;
      logic       fin;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   unidad_control_multiciclo dut0 (
      .clk(clk), .rst(rst), .OPcode(OPcode), .mem_ready(mem_ready),
      .PCWrite(pcwrite[0]), .PCWriteCond(pcwritecond[0]), .PCWriteCondNe(pcwritecondne[0]),
      .IorD(iord[0]), .MemRead(memread[0]), .MemWrite(memwrite[0]), .IRWrite(irwrite[0]),
      .MemtoReg(memtoreg[0]), .PCSource(pcsource[0]), .ALUOp(aluop[0]),
      .ALUSrcA(alusrca[0]), .ALUSrcB(alusrcb[0]), .RegWrite(regwrite[0]),
      .RegDst(regdst[0]), .estado(estado[0]), .instr_fin(instr_fin[0]),
      .error_code(error_code[0])
   );

   unidad_control_multiciclo #(.EN_BNE(0)) dut1 (
      .clk(clk), .rst(rst), .OPcode(OPcode), .mem_ready(mem_ready),
      .PCWrite(pcwrite[1]), .PCWriteCond(pcwritecond[1]), .PCWriteCondNe(pcwritecondne[1]),
      .IorD(iord[1]), .MemRead(memread[1]), .MemWrite(memwrite[1]), .IRWrite(irwrite[1]),
      .MemtoReg(memtoreg[1]), .PCSource(pcsource[1]), .ALUOp(aluop[1]),
      .ALUSrcA(alusrca[1]), .ALUSrcB(alusrcb[1]), .RegWrite(regwrite[1]),
      .RegDst(regdst[1]), .estado(estado[1]), .instr_fin(instr_fin[1]),
      .error_code(error_code[1])
   );

   unidad_control_multiciclo #(.WAIT_MAX(3)) dut2 (
      .clk(clk), .rst(rst), .OPcode(OPcode), .mem_ready(mem_ready),
      .PCWrite(pcwrite[2]), .PCWriteCond(pcwritecond[2]), .PCWriteCondNe(pcwritecondne[2]),
      .IorD(iord[2]), .MemRead(memread[2]), .MemWrite(memwrite[2]), .IRWrite(irwrite[2]),
      .MemtoReg(memtoreg[2]), .PCSource(pcsource[2]), .ALUOp(aluop[2]),
      .ALUSrcA(alusrca[2]), .ALUSrcB(alusrcb[2]), .RegWrite(regwrite[2]),
      .RegDst(regdst[2]), .estado(estado[2]), .instr_fin(instr_fin[2]),
      .error_code(error_code[2])
   );

   // One clock cycle: drive inputs at the falling edge, queue the expected state,
   // then compare once the outputs have settled. Leaves time before the next rise
   // for the caller's own checks.
   task automatic cyc(input int d, input logic rdy, input logic [3:0] st, input logic fin);
      exp_t e;
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = rdy;
      e.st      = st;
      e.fin     = fin;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if (estado[d] !== e.st) begin
         errors++;
         $display("FAIL estado dut%0d t=%0t: got %0d want %0d", d, $time, estado[d], e.st);
      end
      checks++;
      if (instr_fin[d] !== e.fin) begin
         errors++;
         $display("FAIL instr_fin dut%0d t=%0t: got %b want %b", d, $time, instr_fin[d], e.fin);
      end
      checks++;
      if ((memread[d] === 1'b1 && memwrite[d] === 1'b1) ||
          ($countones({pcwrite[d], pcwritecond[d], pcwritecondne[d]}) > 1)) begin
         errors++;
         $display("FAIL exclusive dut%0d t=%0t: rd/wr %b%b pcw %b%b%b want at most one",
                  d, $time, memread[d], memwrite[d], pcwrite[d], pcwritecond[d],
                  pcwritecondne[d]);
      end
   endtask

   // Asserts reset and leaves it high; the next cyc releases it.
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (estado[d] !== 4'd0 || error_code[d] !== 2'b00) begin
            errors++;
            $display("FAIL reset_state dut%0d: got %0d/%b want 0/00", d, estado[d],
                     error_code[d]);
         end
      end
      checks++;
      if ({memread[0], alusrcb[0], pcwrite[0], irwrite[0], regwrite[0], memwrite[0],
           iord[0], pcsource[0], aluop[0]} !== {1'b1, 2'b01, 9'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b srcb=%b pcw=%b irw=%b want 1 01 0 0",
                  memread[0], alusrcb[0], pcwrite[0], irwrite[0]);
      end
   endtask

   task automatic test_rtype();
      do_reset();
      OPcode = 6'b000000;
      cyc(0, 1'b1, 4'd0, 1'b0);
      checks++;
      if (irwrite[0] !== 1'b1 || pcwrite[0] !== 1'b1) begin
         errors++;
         $display("FAIL fetch_ready: got irw=%b pcw=%b want 1 1", irwrite[0], pcwrite[0]);
      end
      cyc(0, 1'b0, 4'd1, 1'b0);
      checks++;
      if (alusrcb[0] !== 2'b11 || alusrca[0] !== 1'b0) begin
         errors++;
         $display("FAIL decode_alu: got srcb=%b srca=%b want 11 0", alusrcb[0], alusrca[0]);
      end
      cyc(0, 1'b0, 4'd6, 1'b0);
      checks++;
      if (regwrite[0] !== 1'b0 || aluop[0] !== 2'b10 || alusrca[0] !== 1'b1) begin
         errors++;
         $display("FAIL r_ex: got rw=%b aluop=%b srca=%b want 0 10 1", regwrite[0], aluop[0],
                  alusrca[0]);
      end
      cyc(0, 1'b0, 4'd7, 1'b1);
      checks++;
      if (regwrite[0] !== 1'b1 || regdst[0] !== 2'b01 || memtoreg[0] !== 2'b00) begin
         errors++;
         $display("FAIL r_wb: got rw=%b dst=%b m2r=%b want 1 01 00", regwrite[0], regdst[0],
                  memtoreg[0]);
      end
      cyc(0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_lw_wait();
      do_reset();
      OPcode = 6'b100011;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, (i == 3), 4'd3, 1'b0);
         checks++;
         if (memread[0] !== 1'b1 || iord[0] !== 1'b1 || regwrite[0] !== 1'b0) begin
            errors++;
            $display("FAIL mem_rd[%0d]: got rd=%b iord=%b rw=%b want 1 1 0", i, memread[0],
                     iord[0], regwrite[0]);
         end
      end
      cyc(0, 1'b0, 4'd4, 1'b1);
      checks++;
      if (memtoreg[0] !== 2'b01 || regwrite[0] !== 1'b1 || regdst[0] !== 2'b00) begin
         errors++;
         $display("FAIL mem_wb: got m2r=%b rw=%b dst=%b want 01 1 00", memtoreg[0],
                  regwrite[0], regdst[0]);
      end
      cyc(0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_jal();
      do_reset();
      OPcode = 6'b000011;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd10, 1'b1);
      checks++;
      if ({pcwrite[0], regwrite[0], regdst[0], memtoreg[0], pcsource[0]} !==
          {1'b1, 1'b1, 2'b10, 2'b10, 2'b10}) begin
         errors++;
         $display("FAIL jal: got pcw=%b rw=%b dst=%b m2r=%b src=%b want 1 1 10 10 10",
                  pcwrite[0], regwrite[0], regdst[0], memtoreg[0], pcsource[0]);
      end
      cyc(0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_branch(input logic [5:0] op, input logic want_ne);
      do_reset();
      OPcode = op;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd8, 1'b1);
      checks++;
      if (pcwritecondne[0] !== want_ne || pcwritecond[0] !== ~want_ne ||
          pcsource[0] !== 2'b01 || aluop[0] !== 2'b01) begin
         errors++;
         $display("FAIL branch op=%b: got cond=%b ne=%b src=%b aluop=%b want %b %b 01 01", op,
                  pcwritecond[0], pcwritecondne[0], pcsource[0], aluop[0], ~want_ne, want_ne);
      end
      cyc(0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_bne_disabled();
      do_reset();
      OPcode = 6'b000101;
      cyc(1, 1'b1, 4'd0, 1'b0);
      cyc(1, 1'b0, 4'd1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, (i % 2 == 0), 4'd15, 1'b0);
         checks++;
         if (error_code[1] !== 2'b01 || memread[1] !== 1'b0 || pcwrite[1] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold[%0d]: got err=%b rd=%b pcw=%b want 01 0 0", i,
                     error_code[1], memread[1], pcwrite[1]);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      OPcode = 6'b000000;
      for (int i = 0; i < 4; i++) cyc(2, 1'b0, 4'd0, 1'b0);
      cyc(2, 1'b1, 4'd15, 1'b0);
      checks++;
      if (error_code[2] !== 2'b10 || memread[2] !== 1'b0 || irwrite[2] !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got err=%b rd=%b irw=%b want 10 0 0", error_code[2],
                  memread[2], irwrite[2]);
      end
      // Ready on the last permitted cycle wins over the timeout.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(2, 1'b0, 4'd0, 1'b0);
      cyc(2, 1'b1, 4'd0, 1'b0);
      cyc(2, 1'b0, 4'd1, 1'b0);
      checks++;
      if (error_code[2] !== 2'b00) begin
         errors++;
         $display("FAIL ready_wins: got err=%b want 00", error_code[2]);
      end
   endtask

   task automatic test_reset_in_mem_wr();
      do_reset();
      OPcode = 6'b101011;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd2, 1'b0);
      cyc(0, 1'b0, 4'd5, 1'b0);
      checks++;
      if (memwrite[0] !== 1'b1 || iord[0] !== 1'b1 || memread[0] !== 1'b0) begin
         errors++;
         $display("FAIL mem_wr: got wr=%b iord=%b rd=%b want 1 1 0", memwrite[0], iord[0],
                  memread[0]);
      end
      #2;
      rst       = 1'b1;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (estado[0] !== 4'd0 || memwrite[0] !== 1'b0 || error_code[0] !== 2'b00 ||
          pcwrite[0] !== 1'b0 || irwrite[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_wr: got st=%0d wr=%b err=%b pcw=%b irw=%b want 0 0 00 0 0",
                  estado[0], memwrite[0], error_code[0], pcwrite[0], irwrite[0]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      OPcode = 6'b001000;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd11, 1'b0);
      checks++;
      if (alusrca[0] !== 1'b1 || alusrcb[0] !== 2'b10 || aluop[0] !== 2'b00) begin
         errors++;
         $display("FAIL i_ex: got srca=%b srcb=%b aluop=%b want 1 10 00", alusrca[0],
                  alusrcb[0], aluop[0]);
      end
      cyc(0, 1'b0, 4'd12, 1'b1);
      checks++;
      if (regwrite[0] !== 1'b1 || regdst[0] !== 2'b00 || memtoreg[0] !== 2'b00) begin
         errors++;
         $display("FAIL i_wb: got rw=%b dst=%b m2r=%b want 1 00 00", regwrite[0], regdst[0],
                  memtoreg[0]);
      end
      OPcode = 6'b000010;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd9, 1'b1);
      checks++;
      if (pcwrite[0] !== 1'b1 || pcsource[0] !== 2'b10 || regwrite[0] !== 1'b0) begin
         errors++;
         $display("FAIL jump: got pcw=%b src=%b rw=%b want 1 10 0", pcwrite[0], pcsource[0],
                  regwrite[0]);
      end
      OPcode = 6'b111111;
      cyc(0, 1'b1, 4'd0, 1'b0);
      cyc(0, 1'b0, 4'd1, 1'b0);
      cyc(0, 1'b0, 4'd15, 1'b0);
      checks++;
      if (error_code[0] !== 2'b01) begin
         errors++;
         $display("FAIL illegal_op: got err=%b want 01", error_code[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_jal();
      test_branch(6'b000100, 1'b0);
      test_branch(6'b000101, 1'b1);
      test_bne_disabled();
      test_timeout();
      test_reset_in_mem_wr();
      test_back_to_back();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
